ctrl_relogio: RTL

CTRL_RELOGIO -- requirements
Module: ctrl_relogio

---
 rtl/relogio_pkg.sv | 29 ++
 rtl/ctrl_debounce.sv | 49 ++++
 rtl/ctrl_relogio.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/relogio_pkg.sv
// Shared types and constants for the clock controller.
package relogio_pkg;

    // Controller operating modes; the encoding is visible on ctrlr_mode.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } relogio_mode_e;

    // BCD limits of the seconds digits.
    localparam logic [3:0] SEC_LSD_MAX = 4'd9;
    localparam logic [2:0] SEC_MSD_MAX = 3'd5;

    // Mode sequence followed on each mode button press.
    function automatic relogio_mode_e next_mode(input relogio_mode_e mode);
        case (mode)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            default:  return RUN;
        endcase
    endfunction

    // True when the seconds digits read 59.
    function automatic logic sec_at_max(input logic [3:0] lsd, input logic [2:0] msd);
        return (lsd == SEC_LSD_MAX) && (msd == SEC_MSD_MAX);
    endfunction

endpackage

// File: rtl/ctrl_debounce.sv
// Debouncer plus rising-edge detector for one already-synchronized button.
// A new level is accepted once it has been seen for DEBOUNCE_CYCLES
// consecutive cycles; deb_press pulses for one cycle when the accepted
// level goes from 0 to 1.
module ctrl_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic deb_clock,
    input  logic deb_reset,
    input  logic deb_level,
    output logic deb_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             prev_q;

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (deb_level != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = deb_level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce counter, accepted level and its one-cycle-delayed copy.
    always_ff @(posedge deb_clock or negedge deb_reset) begin
        if (!deb_reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

    assign deb_press = stable_q & ~prev_q;

endmodule

// File: rtl/ctrl_relogio.sv
// Clock controller: mode FSM, seconds prescaler/counter in BCD, minute and
// hour increment pulses, counter enables and the set-mode blink.
module ctrl_relogio
    import relogio_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       ctrlr_clock,
    input  logic       ctrlr_reset,
    input  logic       ctrlr_btn_mode,
    input  logic       ctrlr_btn_up,
    input  logic       ctrlr_min_carry,
    output logic       ctrlr_min_enable,
    output logic       ctrlr_min_inc,
    output logic       ctrlr_hour_enable,
    output logic       ctrlr_hour_inc,
    output logic [3:0] ctrlr_sec_lsd,
    output logic [2:0] ctrlr_sec_msd,
    output logic [1:0] ctrlr_mode,
    output logic       ctrlr_blink
);

    localparam int unsigned PRESC_W = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    localparam int unsigned BLINK_HALF = CLK_HZ / 4;
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

    // Bit 0 is the mode button, bit 1 the up button.
    logic [1:0] sync1_q, sync2_q;
    logic       press_mode, press_up;

    relogio_mode_e mode_q, mode_d;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         sec_lsd_q, sec_lsd_d;
    logic [2:0]         sec_msd_q, sec_msd_d;

    logic min_inc_q, min_inc_d;
    logic hour_inc_q, hour_inc_d;
    logic min_en_q, min_en_d;
    logic hour_en_q, hour_en_d;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    logic tick;
    logic stay_run;
    logic sec_wrap;
    logic up_ok;

    // Two-flop synchronizers for the raw asynchronous buttons.
    always_ff @(posedge ctrlr_clock or negedge ctrlr_reset) begin
        if (!ctrlr_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {ctrlr_btn_up, ctrlr_btn_mode};
            sync2_q <= sync1_q;
        end
    end

    ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_mode (
        .deb_clock(ctrlr_clock),
        .deb_reset(ctrlr_reset),
        .deb_level(sync2_q[0]),
        .deb_press(press_mode)
    );

    ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .deb_clock(ctrlr_clock),
        .deb_reset(ctrlr_reset),
        .deb_level(sync2_q[1]),
        .deb_press(press_up)
    );

    // Prescaler wrap; only meaningful while running.
    assign tick = (mode_q == RUN) && (presc_q == PRESC_MAX);

    // Staying in RUN this cycle; a mode press out of RUN drops the tick.
    assign stay_run = (mode_q == RUN) && (mode_d == RUN);
    assign sec_wrap = stay_run && tick && sec_at_max(sec_lsd_q, sec_msd_q);

    // Mode press takes precedence over a simultaneous up press.
    assign up_ok = press_up && !press_mode;

    // Mode FSM next state.
    always_comb begin
        mode_d = mode_q;
        if (press_mode) begin
            mode_d = next_mode(mode_q);
        end
    end

    // Prescaler and BCD seconds; both sit at zero outside RUN and on the
    // first RUN cycle after returning from a set mode.
    always_comb begin
        presc_d   = '0;
        sec_lsd_d = '0;
        sec_msd_d = '0;
        if (stay_run) begin
            sec_lsd_d = sec_lsd_q;
            sec_msd_d = sec_msd_q;
            if (tick) begin
                if (sec_lsd_q == SEC_LSD_MAX) begin
                    sec_lsd_d = '0;
                    sec_msd_d = (sec_msd_q == SEC_MSD_MAX) ? 3'd0 : sec_msd_q + 3'd1;
                end else begin
                    sec_lsd_d = sec_lsd_q + 4'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Increment pulses and enables, all registered.
    always_comb begin
        min_inc_d  = sec_wrap || ((mode_q == SET_MIN) && up_ok);
        hour_inc_d = (sec_wrap && ctrlr_min_carry) || ((mode_q == SET_HOUR) && up_ok);
        min_en_d   = (mode_d == RUN) || (mode_d == SET_MIN);
        hour_en_d  = (mode_d == RUN) || (mode_d == SET_HOUR);
    end

    // Blink generator: restarts high on every entry into a set mode.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (mode_d != RUN) begin
            if (mode_d != mode_q) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_MAX) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge ctrlr_clock or negedge ctrlr_reset) begin
        if (!ctrlr_reset) begin
            mode_q      <= RUN;
            presc_q     <= '0;
            sec_lsd_q   <= '0;
            sec_msd_q   <= '0;
            min_inc_q   <= 1'b0;
            hour_inc_q  <= 1'b0;
            min_en_q    <= 1'b0;
            hour_en_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            sec_lsd_q   <= sec_lsd_d;
            sec_msd_q   <= sec_msd_d;
            min_inc_q   <= min_inc_d;
            hour_inc_q  <= hour_inc_d;
            min_en_q    <= min_en_d;
            hour_en_q   <= hour_en_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign ctrlr_min_enable  = min_en_q;
    assign ctrlr_min_inc     = min_inc_q;
    assign ctrlr_hour_enable = hour_en_q;
    assign ctrlr_hour_inc    = hour_inc_q;
    assign ctrlr_sec_lsd     = sec_lsd_q;
    assign ctrlr_sec_msd     = sec_msd_q;
    assign ctrlr_mode        = mode_q;
    assign ctrlr_blink       = blink_q;

endmodule
